// File: rtl/div_pkg.sv
// Shared DIV definitions: uop codes, issue-sequencer states and the default divider latency.
package div_pkg;

   localparam logic [5:0] UOP_DIV  = 6'b000100;
   localparam logic [5:0] UOP_DIVU = 6'b000101;
   localparam logic [5:0] UOP_REM  = 6'b000110;
   localparam logic [5:0] UOP_REMU = 6'b000111;

   localparam int DIV_LAT_DEF = 35;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_LAUNCH = 2'b01,
      ST_WAIT   = 2'b10,
      ST_DONE   = 2'b11
   } div_state_e;

   function automatic logic is_div_uop(input logic [5:0] u);
      return (u == UOP_DIV) || (u == UOP_DIVU) || (u == UOP_REM) || (u == UOP_REMU);
   endfunction

endpackage

// File: rtl/div_fastpath.sv
// Combinational special-case resolver for divide-by-zero and signed overflow; zero latency,
// no handshake. Only instantiated when DIV_ISSUE_FASTPATH_EN is defined.
module div_fastpath
   import div_pkg::*;
#(
   parameter int W_PD_UOPS = 6,
   parameter int W_PD_DATA = 32
) (
   input  logic [W_PD_UOPS-1:0] uops,
   input  logic [W_PD_DATA-1:0] rs,
   input  logic [W_PD_DATA-1:0] rt,
   output logic                 hit,
   output logic [W_PD_DATA-1:0] res,
   output logic                 ofw
);

   logic [5:0]           uop6;
   logic                 is_rem;
   logic                 is_signed;
   logic [W_PD_DATA-1:0] int_min;

   assign uop6      = 6'(uops);
   assign is_rem    = (uop6 == UOP_REM) || (uop6 == UOP_REMU);
   assign is_signed = (uop6 == UOP_DIV) || (uop6 == UOP_REM);
   assign int_min   = {1'b1, {(W_PD_DATA-1){1'b0}}};

   always_comb begin
      hit = 1'b0;
      res = '0;
      ofw = 1'b0;
      if (is_div_uop(uop6)) begin
         if (rt == '0) begin
            hit = 1'b1;
            res = is_rem ? rs : '1;
         end else if (is_signed && (rs == int_min) && (rt == '1)) begin
            hit = 1'b1;
            ofw = 1'b1;
            res = is_rem ? '0 : int_min;
         end
      end
   end

endmodule

// File: rtl/div_issue_ctrl.sv
// DIV issue sequencer: accept -> 1-cycle launch -> DIV_LAT wait -> hold result until writeback ready.
// Busy (ready=0) from accept until result handshake; optional DIV_ISSUE_FASTPATH_EN resolves special cases in IDLE.
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int W_PD_UOPS = 6,
   parameter int W_PD_DATA = 32,
   parameter int W_PD_TAG  = 5,
   parameter int DIV_LAT   = DIV_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 CFI_PC_clear,
   input  logic                 CFI_PC_valid,
   output logic                 CFO_PC_ready,
   input  logic [W_PD_UOPS-1:0] DFI_PD_uops,
   input  logic [W_PD_DATA-1:0] DFI_PD_rs,
   input  logic [W_PD_DATA-1:0] DFI_PD_rt,
   input  logic [W_PD_TAG-1:0]  DFI_PD_tag,
   output logic                 CFO_PC_divEna,
   output logic                 CFO_PC_divClear,
   output logic [W_PD_UOPS-1:0] DFO_PD_divUops,
   output logic [W_PD_DATA-1:0] DFO_PD_divRs,
   output logic [W_PD_DATA-1:0] DFO_PD_divRt,
   input  logic [W_PD_DATA-1:0] DFI_PD_divRs,
   input  logic                 DFI_PD_divOfw,
   output logic                 CFO_PC_resValid,
   input  logic                 CFI_PC_resReady,
   output logic [W_PD_DATA-1:0] DFO_PD_res,
   output logic                 DFO_PD_resOfw,
   output logic [W_PD_TAG-1:0]  DFO_PD_resTag
);

   localparam int W_CNT = $clog2(DIV_LAT + 1);

   div_state_e           state_q, state_d;
   logic [W_CNT-1:0]     cnt_q, cnt_d;
   logic [W_PD_UOPS-1:0] uops_q, uops_d;
   logic [W_PD_DATA-1:0] rs_q, rs_d;
   logic [W_PD_DATA-1:0] rt_q, rt_d;
   logic [W_PD_TAG-1:0]  tag_q, tag_d;
   logic [W_PD_DATA-1:0] res_q, res_d;
   logic                 ofw_q, ofw_d;

   logic                 fp_hit;
   logic [W_PD_DATA-1:0] fp_res;
   logic                 fp_ofw;

`ifdef DIV_ISSUE_FASTPATH_EN
   div_fastpath #(
      .W_PD_UOPS (W_PD_UOPS),
      .W_PD_DATA (W_PD_DATA)
   ) u_fastpath (
      .uops (DFI_PD_uops),
      .rs   (DFI_PD_rs),
      .rt   (DFI_PD_rt),
      .hit  (fp_hit),
      .res  (fp_res),
      .ofw  (fp_ofw)
   );
`else
   assign fp_hit = 1'b0;
   assign fp_res = '0;
   assign fp_ofw = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      uops_d          = uops_q;
      rs_d            = rs_q;
      rt_d            = rt_q;
      tag_d           = tag_q;
      res_d           = res_q;
      ofw_d           = ofw_q;
      CFO_PC_ready    = 1'b0;
      CFO_PC_divEna   = 1'b0;
      CFO_PC_resValid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            CFO_PC_ready = 1'b1;
            if (CFI_PC_valid) begin
               uops_d = DFI_PD_uops;
               rs_d   = DFI_PD_rs;
               rt_d   = DFI_PD_rt;
               tag_d  = DFI_PD_tag;
               if (!is_div_uop(6'(DFI_PD_uops))) begin
                  res_d   = '0;
                  ofw_d   = 1'b0;
                  state_d = ST_DONE;
               end else if (fp_hit) begin
                  res_d   = fp_res;
                  ofw_d   = fp_ofw;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_LAUNCH;
               end
            end
         end
         ST_LAUNCH: begin
            CFO_PC_divEna = 1'b1;
            cnt_d         = W_CNT'(1);
            state_d       = ST_WAIT;
         end
         ST_WAIT: begin
            // Count saturates at DIV_LAT: the capture cycle is the last one spent here.
            if (cnt_q == W_CNT'(DIV_LAT)) begin
               res_d   = DFI_PD_divRs;
               ofw_d   = DFI_PD_divOfw;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + W_CNT'(1);
            end
         end
         ST_DONE: begin
            CFO_PC_resValid = 1'b1;
            if (CFI_PC_resReady) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (CFI_PC_clear) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         uops_q  <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         tag_q   <= '0;
         res_q   <= '0;
         ofw_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         uops_q  <= uops_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         tag_q   <= tag_d;
         res_q   <= res_d;
         ofw_q   <= ofw_d;
      end
   end

   assign CFO_PC_divClear = CFI_PC_clear;
   assign DFO_PD_divUops  = uops_q;
   assign DFO_PD_divRs    = rs_q;
   assign DFO_PD_divRt    = rt_q;
   assign DFO_PD_res      = res_q;
   assign DFO_PD_resOfw   = ofw_q;
   assign DFO_PD_resTag   = tag_q;

endmodule
